// File: rtl/period_meter.sv
// period_meter: synchronizes an asynchronous slow signal into clk_in and reports its
// period and high time per rising edge over valid/ready. PERIOD_METER_MINMAX_EN adds period_min/period_max.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             dropped
`ifdef PERIOD_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic [CNT_W-1:0]       pcnt_r;
    logic [CNT_W-1:0]       hcnt_r;
    logic                   ovf_int_r;
    logic [CNT_W-1:0]       period_r;
    logic [CNT_W-1:0]       high_time_r;
    logic                   ovf_r;
    logic                   res_valid_r;
    logic                   dropped_r;

    logic synced_s;
    logic edge_s;
    logic meas_edge_s;
    logic capture_s;
    logic drop_s;
    logic arm_entry_s;

    assign synced_s    = sync_r[SYNC_STAGES-1];
    assign edge_s      = synced_s & ~hist_r;
    assign meas_edge_s = (state_r == ST_MEAS) & edge_s;
    assign capture_s   = meas_edge_s & (~res_valid_r | res_ready);
    assign drop_s      = meas_edge_s & res_valid_r & ~res_ready;
    assign arm_entry_s = (state_r == ST_IDLE) & enable;

    // Synchronizer chain plus history flop for rising-edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            hist_r <= synced_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; enable low always wins.
    always_comb begin
        state_nxt_s = state_r;
        if (!enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_ARM;
                ST_ARM: begin
                    if (edge_s) begin
                        state_nxt_s = ST_MEAS;
                    end else begin
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_MEAS: state_nxt_s = ST_MEAS;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Period/high counters: restart on every edge once armed, saturate instead of wrapping.
    // ovf_int flags an increment attempted at saturation, so a period of exactly CNT_MAX is not an overflow.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r    <= CNT_ZERO;
            hcnt_r    <= CNT_ZERO;
            ovf_int_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            pcnt_r    <= CNT_ZERO;
            hcnt_r    <= CNT_ZERO;
            ovf_int_r <= 1'b0;
        end else if (edge_s) begin
            pcnt_r    <= CNT_ONE;
            hcnt_r    <= CNT_ONE;
            ovf_int_r <= 1'b0;
        end else if (state_r == ST_MEAS) begin
            if (pcnt_r != CNT_MAX) begin
                pcnt_r <= pcnt_r + CNT_ONE;
            end else begin
                ovf_int_r <= 1'b1;
            end
            if (synced_s && (hcnt_r != CNT_MAX)) begin
                hcnt_r <= hcnt_r + CNT_ONE;
            end
        end
    end

    // Result capture and valid/ready handshake; a new capture beats a same-cycle transfer.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            period_r    <= CNT_ZERO;
            high_time_r <= CNT_ZERO;
            ovf_r       <= 1'b0;
            res_valid_r <= 1'b0;
            dropped_r   <= 1'b0;
        end else begin
            if (capture_s) begin
                period_r    <= pcnt_r;
                high_time_r <= hcnt_r;
                ovf_r       <= ovf_int_r;
                res_valid_r <= 1'b1;
            end else if (res_valid_r && res_ready) begin
                res_valid_r <= 1'b0;
            end
            if (drop_s) begin
                dropped_r <= 1'b1;
            end
        end
    end

    assign period    = period_r;
    assign high_time = high_time_r;
    assign ovf       = ovf_r;
    assign res_valid = res_valid_r;
    assign dropped   = dropped_r;

`ifdef PERIOD_METER_MINMAX_EN
    logic [CNT_W-1:0] period_min_r;
    logic [CNT_W-1:0] period_max_r;

    // Running extremes over every capture, dropped ones included; cleared on entry to ARM.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            period_min_r <= CNT_MAX;
            period_max_r <= CNT_ZERO;
        end else if (arm_entry_s) begin
            period_min_r <= CNT_MAX;
            period_max_r <= CNT_ZERO;
        end else if (meas_edge_s) begin
            if (pcnt_r < period_min_r) begin
                period_min_r <= pcnt_r;
            end
            if (pcnt_r > period_max_r) begin
                period_max_r <= pcnt_r;
            end
        end
    end

    assign period_min = period_min_r;
    assign period_max = period_max_r;
`else
    logic unused_s;
    assign unused_s = arm_entry_s;
`endif

endmodule
